// File: rtl/l2_msg2_resp_serializer.sv
// rtl/l2_msg2_resp_serializer.sv - L2 msg2 response FIFO and NoC2 flit serializer
//
// Buffers msg2 responses (type, dest, tag, data) in a DEPTH-entry FIFO and
// serializes each one onto a DATA_W-bit NoC2 flit channel. Every message
// gets one header flit. Data-bearing types (8'h13, 8'h14) also get one data flit.
//
// Optional feature macro: L2_RESP_STALL_CNT_EN (adds noc2_stall_cnt).
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   msg2_valid/ready  response offer / accept (valid && ready)
//   msg2_type/dest/tag/data  response fields
//   noc2_valid/ready  flit offer / accept (valid && ready)
//   noc2_flit         flit payload
//   noc2_last         final flit of the current message
//   resp_count        entries currently held
//   noc2_stall_cnt    (macro only) saturating count of stalled flit cycles
module l2_msg2_resp_serializer #(
    parameter int DEPTH  = 4,
    parameter int TYPE_W = 8,
    parameter int SRC_W  = 6,
    parameter int TAG_W  = 26,
    parameter int DATA_W = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     msg2_valid,
    output logic                     msg2_ready,
    input  logic [TYPE_W-1:0]        msg2_type,
    input  logic [SRC_W-1:0]         msg2_dest,
    input  logic [TAG_W-1:0]         msg2_tag,
    input  logic [DATA_W-1:0]        msg2_data,
    output logic                     noc2_valid,
    input  logic                     noc2_ready,
    output logic [DATA_W-1:0]        noc2_flit,
    output logic                     noc2_last,
    output logic [$clog2(DEPTH):0]   resp_count
`ifdef L2_RESP_STALL_CNT_EN
    ,
    output logic [15:0]              noc2_stall_cnt
`endif
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;
    localparam int PAD_W = DATA_W - TYPE_W - SRC_W - TAG_W;

    typedef enum logic {
        S_HDR  = 1'b0,
        S_DATA = 1'b1
    } state_t;

    logic [TYPE_W-1:0] type_mem [DEPTH];
    logic [SRC_W-1:0]  dest_mem [DEPTH];
    logic [TAG_W-1:0]  tag_mem  [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    state_t           state_q, state_d;
    logic             full, empty, push, pop;
    logic             head_db;
    logic [TYPE_W-1:0] head_type;
    logic [SRC_W-1:0]  head_dest;
    logic [TAG_W-1:0]  head_tag;
    logic [DATA_W-1:0] head_data;

    // Same index bits with differing wrap bits means the writer lapped the reader.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign resp_count = wr_ptr - rd_ptr;

    // Ready depends only on registered occupancy, so a pop in a full cycle
    // cannot make room for a push in that same cycle.
    assign msg2_ready = rst_n & ~full;
    assign push       = msg2_valid & msg2_ready;

    assign head_type = type_mem[rd_ptr[AW-1:0]];
    assign head_dest = dest_mem[rd_ptr[AW-1:0]];
    assign head_tag  = tag_mem[rd_ptr[AW-1:0]];
    assign head_data = data_mem[rd_ptr[AW-1:0]];
    assign head_db   = (head_type == TYPE_W'(8'h13)) || (head_type == TYPE_W'(8'h14));

    always_ff @(posedge clk) begin
        if (push) begin
            type_mem[wr_ptr[AW-1:0]] <= msg2_type;
            dest_mem[wr_ptr[AW-1:0]] <= msg2_dest;
            tag_mem[wr_ptr[AW-1:0]]  <= msg2_tag;
            data_mem[wr_ptr[AW-1:0]] <= msg2_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            state_q <= S_HDR;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            state_q <= state_d;
        end
    end

    // The head entry stays in the FIFO until its last flit is accepted, so
    // flit contents are stable under backpressure without a separate holding register.
    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        noc2_valid = 1'b0;
        noc2_flit  = '0;
        noc2_last  = 1'b0;
        if (!empty) begin
            noc2_valid = 1'b1;
            case (state_q)
                S_HDR: begin
                    noc2_flit = {head_type, head_dest, head_tag, {PAD_W{1'b0}}};
                    noc2_last = ~head_db;
                    if (noc2_ready) begin
                        if (head_db) begin
                            state_d = S_DATA;
                        end else begin
                            pop = 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    noc2_flit = head_data;
                    noc2_last = 1'b1;
                    if (noc2_ready) begin
                        pop     = 1'b1;
                        state_d = S_HDR;
                    end
                end
                default: state_d = S_HDR;
            endcase
        end
    end

`ifdef L2_RESP_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            noc2_stall_cnt <= '0;
        end else if (noc2_valid && !noc2_ready && (noc2_stall_cnt != 16'hFFFF)) begin
            noc2_stall_cnt <= noc2_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_l2_msg2_resp_serializer.sv
// tb/tb_l2_msg2_resp_serializer.sv - self-checking bench for l2_msg2_resp_serializer
module tb_l2_msg2_resp_serializer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        msg2_valid = 1'b0;
    logic        msg2_ready;
    logic [7:0]  msg2_type = '0;
    logic [5:0]  msg2_dest = '0;
    logic [25:0] msg2_tag = '0;
    logic [63:0] msg2_data = '0;
    logic        noc2_valid;
    logic        noc2_ready = 1'b0;
    logic [63:0] noc2_flit;
    logic        noc2_last;
    logic [2:0]  resp_count;
`ifdef L2_RESP_STALL_CNT_EN
    logic [15:0] noc2_stall_cnt;
`endif

    l2_msg2_resp_serializer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .msg2_valid(msg2_valid), .msg2_ready(msg2_ready),
        .msg2_type(msg2_type), .msg2_dest(msg2_dest),
        .msg2_tag(msg2_tag), .msg2_data(msg2_data),
        .noc2_valid(noc2_valid), .noc2_ready(noc2_ready),
        .noc2_flit(noc2_flit), .noc2_last(noc2_last),
        .resp_count(resp_count)
`ifdef L2_RESP_STALL_CNT_EN
        , .noc2_stall_cnt(noc2_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: expected flit stream plus message occupancy.
    typedef struct {
        logic [63:0] flit;
        logic        last;
    } flit_t;
    flit_t fq[$];
    int    m_count = 0;
    int    m_stall = 0;

    logic        obs_valid, obs_last, obs_ready;
    logic [63:0] obs_flit;
    logic [2:0]  obs_count;

    typedef struct {
        logic [7:0]  t;
        logic [5:0]  d;
        logic [25:0] g;
        logic [63:0] dat;
        logic [63:0] hdr;
        logic        db;
    } vec_t;
    vec_t vt[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic is_db(input logic [7:0] t);
        return (t == 8'h13) || (t == 8'h14);
    endfunction

    function automatic void model_reset();
        fq.delete();
        m_count = 0;
        m_stall = 0;
    endfunction

    // One clock: compare outputs at negedge, drive inputs, advance the model.
    task automatic step(input logic v, input logic [7:0] t, input logic [5:0] d,
                        input logic [25:0] g, input logic [63:0] dat, input logic nr);
        logic  exp_valid, acc;
        flit_t f;
        @(negedge clk);
        obs_valid = noc2_valid;
        obs_flit  = noc2_flit;
        obs_last  = noc2_last;
        obs_ready = msg2_ready;
        obs_count = resp_count;
        exp_valid = (fq.size() != 0);
        chk("noc2_valid", 64'(obs_valid), 64'(exp_valid));
        chk("noc2_flit", obs_flit, exp_valid ? fq[0].flit : 64'h0);
        chk("noc2_last", 64'(obs_last), exp_valid ? 64'(fq[0].last) : 64'h0);
        chk("msg2_ready", 64'(obs_ready), 64'(m_count != DEPTH));
        chk("resp_count", 64'(obs_count), 64'(m_count));
`ifdef L2_RESP_STALL_CNT_EN
        chk("stall_cnt", 64'(noc2_stall_cnt), 64'(m_stall));
`endif
        msg2_valid = v;
        msg2_type  = t;
        msg2_dest  = d;
        msg2_tag   = g;
        msg2_data  = dat;
        noc2_ready = nr;
        acc = v && (m_count != DEPTH);
        if (exp_valid && !nr && m_stall != 65535) m_stall++;
        if (exp_valid && nr) begin
            if (fq[0].last) m_count--;
            void'(fq.pop_front());
        end
        if (acc) begin
            f.flit = {t, d, g, 24'h0};
            f.last = !is_db(t);
            fq.push_back(f);
            if (is_db(t)) begin
                f.flit = dat;
                f.last = 1'b1;
                fq.push_back(f);
            end
            m_count++;
        end
    endtask

    task automatic idle(input logic nr);
        step(1'b0, 8'h00, 6'h00, 26'h0, 64'h0, nr);
    endtask

    initial begin
        logic [7:0] rt;
        vt[0] = '{8'h11, 6'h05, 26'h0ABCDEF, 64'h0, 64'h1114ABCDEF000000, 1'b0};
        vt[1] = '{8'h14, 6'h3F, 26'h3FFFFFF, 64'hDEADBEEF_CAFEF00D, 64'h14FFFFFFFF000000, 1'b1};
        vt[2] = '{8'h13, 6'h00, 26'h0, 64'h0123456789ABCDEF, 64'h1300000000000000, 1'b1};
        vt[3] = '{8'hFF, 6'h2A, 26'h1234567, 64'hFFFF_0000_FFFF_0000, 64'hFFA9234567000000, 1'b0};
        vt[4] = '{8'h12, 6'h01, 26'h0000001, 64'h5555_5555_5555_5555, 64'h1204000001000000, 1'b0};
        vt[5] = '{8'h15, 6'h00, 26'h0, 64'hAAAA_AAAA_AAAA_AAAA, 64'h1500000000000000, 1'b0};

        // Reset state
        #12;
        chk("rst_msg2_ready", 64'(msg2_ready), 64'h0);
        chk("rst_noc2_valid", 64'(noc2_valid), 64'h0);
        chk("rst_noc2_flit", noc2_flit, 64'h0);
        chk("rst_resp_count", 64'(resp_count), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Table vectors: each pushed alone with noc2_ready=1
        for (int i = 0; i < 6; i++) begin
            step(1'b1, vt[i].t, vt[i].d, vt[i].g, vt[i].dat, 1'b1);
            idle(1'b1);
            chk("tbl_hdr_valid", 64'(obs_valid), 64'h1);
            chk("tbl_hdr_flit", obs_flit, vt[i].hdr);
            chk("tbl_hdr_last", 64'(obs_last), 64'(!vt[i].db));
            if (vt[i].db) begin
                idle(1'b1);
                chk("tbl_data_flit", obs_flit, vt[i].dat);
                chk("tbl_data_last", 64'(obs_last), 64'h1);
            end
            idle(1'b1);
            chk("tbl_done_valid", 64'(obs_valid), 64'h0);
            chk("tbl_done_count", 64'(obs_count), 64'h0);
        end

        // Fill with noc2_ready=0, 5th offer stalls, pop-cycle refusal
        for (int i = 0; i < 4; i++)
            step(1'b1, 8'h20 + 8'(i), 6'(i), 26'(i * 3), 64'(i), 1'b0);
        step(1'b1, 8'h30, 6'h1, 26'h1, 64'h0, 1'b0);
        chk("full_ready", 64'(obs_ready), 64'h0);
        chk("full_count", 64'(obs_count), 64'h4);
        step(1'b1, 8'h31, 6'h2, 26'h2, 64'h0, 1'b1);
        chk("pop_cycle_ready", 64'(obs_ready), 64'h0);
        step(1'b1, 8'h32, 6'h3, 26'h3, 64'h0, 1'b0);
        chk("after_pop_count", 64'(obs_count), 64'h3);
        chk("after_pop_ready", 64'(obs_ready), 64'h1);
        idle(1'b0);
        chk("refill_count", 64'(obs_count), 64'h4);
        for (int i = 0; i < 20 && fq.size() != 0; i++) idle(1'b1);
        chk("drain_empty", 64'(fq.size()), 64'h0);

        // Reset between header and data flit of an 8'h13
        step(1'b1, 8'h13, 6'h07, 26'h0000ABC, 64'h1111_2222_3333_4444, 1'b1);
        idle(1'b1);
        @(negedge clk);
        chk("mid_data_valid", 64'(noc2_valid), 64'h1);
        chk("mid_data_flit", noc2_flit, 64'h1111_2222_3333_4444);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(noc2_valid), 64'h0);
        chk("async_rst_count", 64'(resp_count), 64'h0);
        chk("async_rst_ready", 64'(msg2_ready), 64'h0);
        chk("async_rst_last", 64'(noc2_last), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) idle(1'b1);

`ifdef L2_RESP_STALL_CNT_EN
        step(1'b1, 8'h11, 6'h05, 26'h0ABCDEF, 64'h0, 1'b0);
        for (int i = 0; i < 10; i++) idle(1'b0);
        @(negedge clk);
        chk("stall_cnt_10", 64'(noc2_stall_cnt), 64'd10);
        for (int i = 0; i < 6; i++) idle(1'b1);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 4))
                0: rt = 8'h11;
                1: rt = 8'h13;
                2: rt = 8'h14;
                3: rt = 8'h12;
                default: rt = 8'($urandom);
            endcase
            step(1'($urandom), rt, 6'($urandom), 26'($urandom), {$urandom, $urandom},
                 ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 20 && fq.size() != 0; i++) idle(1'b1);
        idle(1'b1);
        chk("final_empty", 64'(fq.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
